tcdm_master_shim: RTL and testbench

- Per-master request/response adapter sitting directly upstream of the radix-2 butterfly TCDM network; one instance per network input port.
- Converts a core-side valid/ready load/store interface into the network's req/gnt/add/data + one-cycle-later vld/rdata protocol.
- Holds requests stable until granted and splits the byte address into bank select and row.
- Buffers responses in a credit-protected FIFO so core back-pressure never drops network responses.

---
 rtl/tcdm_pkg.sv | 20 ++
 rtl/tcdm_resp_fifo.sv | 60 ++++++
 rtl/tcdm_master_shim.sv | 129 ++++++++++++
 tb/tb_tcdm_master_shim.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_pkg.sv
// tcdm_pkg: payload layout shared by the TCDM master shim and its FIFO.
// net_data_o packs {row, wen, be, wdata}, MSB to LSB.
package tcdm_pkg;

   typedef enum logic [1:0] {
      FldWdata = 2'd0,
      FldBe    = 2'd1,
      FldWen   = 2'd2,
      FldRow   = 2'd3
   } req_fld_e;

   function automatic int unsigned req_data_width(
      input int unsigned aw,
      input int unsigned dw,
      input int unsigned nb
   );
      return (aw - $clog2(dw / 8) - $clog2(nb)) + 1 + dw / 8 + dw;
   endfunction

endpackage

// File: rtl/tcdm_resp_fifo.sv
// tcdm_resp_fifo: small response FIFO, output read straight from flops.
// Simultaneous push and pop are both honoured.
module tcdm_resp_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic [Width-1:0]             data_i,
   input  logic                         pop_i,
   output logic [Width-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q + CntW'(push_i) - CntW'(pop_i);
      if (push_i) wptr_d = incr(wptr_q);
      if (pop_i)  rptr_d = incr(rptr_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_i) mem_q[wptr_q] <= data_i;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      pop_i |-> !empty_o);

endmodule

// File: rtl/tcdm_master_shim.sv
// tcdm_master_shim: core valid/ready to TCDM req/gnt + vld adapter.
// Responses are credit-protected so core stalls never drop them.
module tcdm_master_shim
   import tcdm_pkg::*;
#(
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned NumBanks     = 32,
   parameter int unsigned BankAddWidth = $clog2(NumBanks),
   parameter int unsigned ByteOffWidth = $clog2(DataWidth / 8),
   parameter int unsigned RowWidth     = AddrWidth - ByteOffWidth - BankAddWidth,
   parameter int unsigned ReqDataWidth = req_data_width(AddrWidth, DataWidth, NumBanks),
   parameter int unsigned RespDepth    = 2,
   parameter bit          WriteRespOn  = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [AddrWidth-1:0]    req_addr_i,
   input  logic                    req_wen_i,
   input  logic [DataWidth/8-1:0]  req_be_i,
   input  logic [DataWidth-1:0]    req_wdata_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [DataWidth-1:0]    resp_rdata_o,
   output logic                    net_req_o,
   input  logic                    net_gnt_i,
   output logic [BankAddWidth-1:0] net_add_o,
   output logic                    net_wen_o,
   output logic [ReqDataWidth-1:0] net_data_o,
   input  logic [DataWidth-1:0]    net_rdata_i,
   input  logic                    net_vld_i
);

   localparam int unsigned CntW     = $clog2(RespDepth + 3);
   localparam int unsigned FifoCntW = $clog2(RespDepth + 1);

   logic                    slot_full_q, slot_full_d;
   logic [BankAddWidth-1:0] add_q, add_d;
   logic                    wen_q, wen_d;
   logic [ReqDataWidth-1:0] data_q, data_d;
   logic                    inflight_q, inflight_d;

   logic                gnt, accept, slot_needs, in_needs;
   logic                push, pop, fifo_full, fifo_empty;
   logic [FifoCntW-1:0] fifo_cnt;
   logic [CntW-1:0]     used, used_net;
   logic                unused_addr;

   assign unused_addr = ^req_addr_i[ByteOffWidth-1:0];

   assign gnt        = slot_full_q & net_gnt_i;
   assign slot_needs = ~wen_q | WriteRespOn;
   assign in_needs   = ~req_wen_i | WriteRespOn;

   // Every response-producing request owns a credit from accept to pop.
   assign used = CntW'(fifo_cnt) + CntW'(inflight_q)
               + CntW'(slot_full_q & slot_needs);
   assign used_net = used - CntW'(pop);

   assign req_ready_o = (~slot_full_q | gnt)
                      & (~in_needs | (used_net < CntW'(RespDepth)));
   assign accept = req_valid_i & req_ready_o;

   always_comb begin
      slot_full_d = slot_full_q & ~gnt;
      add_d       = add_q;
      wen_d       = wen_q;
      data_d      = data_q;
      if (accept) begin
         slot_full_d = 1'b1;
         add_d       = req_addr_i[ByteOffWidth +: BankAddWidth];
         wen_d       = req_wen_i;
         data_d      = {req_addr_i[AddrWidth-1 -: RowWidth],
                        req_wen_i, req_be_i, req_wdata_i};
      end
   end

   assign inflight_d = gnt & slot_needs;
   assign push       = inflight_q & net_vld_i;
   assign pop        = ~fifo_empty & resp_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_full_q <= 1'b0;
         add_q       <= '0;
         wen_q       <= 1'b0;
         data_q      <= '0;
         inflight_q  <= 1'b0;
      end else begin
         slot_full_q <= slot_full_d;
         add_q       <= add_d;
         wen_q       <= wen_d;
         data_q      <= data_d;
         inflight_q  <= inflight_d;
      end
   end

   assign net_req_o  = slot_full_q;
   assign net_add_o  = add_q;
   assign net_wen_o  = wen_q;
   assign net_data_o = data_q;

   tcdm_resp_fifo #(
      .Depth (RespDepth),
      .Width (DataWidth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (net_rdata_i),
      .pop_i   (pop),
      .data_o  (resp_rdata_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign resp_valid_o = ~fifo_empty;

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      net_vld_i |-> inflight_q);
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      inflight_q |-> net_vld_i);
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_tcdm_master_shim.sv
// tb_tcdm_master_shim: directed bench for three shim variants
// (depth 2 with write resp, depth 2 without, depth 4 with).
module tb_tcdm_master_shim;

   localparam int N = 3;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i, req_wen_i, resp_ready_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_be_i;
   logic [31:0] rd_base;
   logic        gnt_en;

   logic        req_ready  [N];
   logic        resp_valid [N];
   logic [31:0] resp_rdata [N];
   logic        net_req    [N];
   logic        net_wen    [N];
   logic [4:0]  net_add    [N];
   logic [61:0] net_data   [N];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk_i = ~clk_i;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam bit WR = (g != 1);
      logic        gnt;
      logic        vld_q;
      logic [31:0] rdata_q;

      tcdm_master_shim #(
         .RespDepth   ((g == 2) ? 4 : 2),
         .WriteRespOn (WR)
      ) u_dut (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .req_valid_i  (req_valid_i),
         .req_ready_o  (req_ready[g]),
         .req_addr_i   (req_addr_i),
         .req_wen_i    (req_wen_i),
         .req_be_i     (req_be_i),
         .req_wdata_i  (req_wdata_i),
         .resp_valid_o (resp_valid[g]),
         .resp_ready_i (resp_ready_i),
         .resp_rdata_o (resp_rdata[g]),
         .net_req_o    (net_req[g]),
         .net_gnt_i    (gnt),
         .net_add_o    (net_add[g]),
         .net_wen_o    (net_wen[g]),
         .net_data_o   (net_data[g]),
         .net_rdata_i  (rdata_q),
         .net_vld_i    (vld_q)
      );

      assign gnt = gnt_en & net_req[g];

      // Bank model: answers one cycle after grant with rd_base ^ address.
      always @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_q   <= 1'b0;
            rdata_q <= '0;
         end else begin
            vld_q   <= gnt & (~net_wen[g] | WR);
            rdata_q <= rd_base ^ {net_data[g][61:37], net_add[g], 2'b00};
         end
      end
   end

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      req_valid_i  = 1'b0;
      resp_ready_i = 1'b1;
      gnt_en       = 1'b1;
      repeat (n) nxt();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) nxt();
      #3;
      chk_cnt++;
      if (net_req[0] !== 1'b0) $display("FAIL rst_req: got %b exp 0", net_req[0]);
      else pass_cnt++;
      chk_cnt++;
      if (resp_valid[0] !== 1'b0) $display("FAIL rst_rvalid: got %b exp 0", resp_valid[0]);
      else pass_cnt++;
      chk_cnt++;
      if (net_data[0] !== 62'd0) $display("FAIL rst_data: got %h exp 0", net_data[0]);
      else pass_cnt++;
      chk_cnt++;
      if (req_ready[0] !== 1'b1) $display("FAIL rst_ready: got %b exp 1", req_ready[0]);
      else pass_cnt++;
      nxt();
      rst_ni = 1'b1;
      nxt();
   endtask

   task automatic test_read_latency();
      rd_base = 32'hDEAD_BEEF ^ 32'h0000_0104;
      gnt_en = 1'b1;
      resp_ready_i = 1'b1;
      nxt();
      req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h0000_0104;
      #3;
      chk_cnt++;
      if (req_ready[0] !== 1'b1) $display("FAIL lat_ready: got %b exp 1", req_ready[0]);
      else pass_cnt++;
      nxt();
      req_valid_i = 1'b0;
      #3;
      chk_cnt++;
      if (net_req[0] !== 1'b1) $display("FAIL lat_req: got %b exp 1", net_req[0]);
      else pass_cnt++;
      chk_cnt++;
      if (net_add[0] !== 5'd1) $display("FAIL lat_bank: got %0d exp 1", net_add[0]);
      else pass_cnt++;
      chk_cnt++;
      if (net_data[0][61:37] !== 25'd2) $display("FAIL lat_row: got %0d exp 2", net_data[0][61:37]);
      else pass_cnt++;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) begin nxt(); #3; end
         chk_cnt++;
         if (resp_valid[0] !== (c == 3))
            $display("FAIL lat_rvalid c%0d: got %b exp %b", c, resp_valid[0], c == 3);
         else pass_cnt++;
      end
   endtask

   task automatic test_read_data();
      rd_base = 32'hDEAD_BEEF ^ 32'h0000_0104;
      gnt_en = 1'b1;
      resp_ready_i = 1'b0;
      nxt();
      req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h0000_0104;
      nxt();
      req_valid_i = 1'b0;
      nxt(); nxt();
      #3;
      chk_cnt++;
      if (resp_rdata[0] !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h exp deadbeef", resp_rdata[0]);
      else pass_cnt++;
      idle(3);
   endtask

   task automatic test_write_hold();
      logic [61:0] exp;
      exp = {25'd1, 1'b1, 4'hF, 32'h1234_5678};
      rd_base = '0;
      gnt_en = 1'b0;
      resp_ready_i = 1'b1;
      nxt();
      req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = 32'h80;
      req_be_i = 4'hF; req_wdata_i = 32'h1234_5678;
      #3;
      chk_cnt++;
      if (req_ready[0] !== 1'b1) $display("FAIL wr_ready0: got %b exp 1", req_ready[0]);
      else pass_cnt++;
      for (int k = 1; k <= 5; k++) begin
         nxt();
         req_valid_i = 1'b0;
         gnt_en = (k == 5);
         #3;
         chk_cnt++;
         if (net_req[0] !== 1'b1 || net_data[0] !== exp || net_add[0] !== 5'd0)
            $display("FAIL wr_hold c%0d: got req=%b data=%h add=%0d exp req=1 data=%h add=0",
                     k, net_req[0], net_data[0], net_add[0], exp);
         else pass_cnt++;
         chk_cnt++;
         if (req_ready[0] !== (k == 5))
            $display("FAIL wr_ready c%0d: got %b exp %b", k, req_ready[0], k == 5);
         else pass_cnt++;
      end
      for (int k = 6; k <= 9; k++) begin
         nxt();
         #3;
         chk_cnt++;
         if (resp_valid[0] !== (k == 7))
            $display("FAIL wr_resp_on c%0d: got %b exp %b", k, resp_valid[0], k == 7);
         else pass_cnt++;
         chk_cnt++;
         if (resp_valid[1] !== 1'b0)
            $display("FAIL wr_resp_off c%0d: got %b exp 0", k, resp_valid[1]);
         else pass_cnt++;
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      rd_base = 32'h5A5A_0000;
      gnt_en = 1'b1;
      resp_ready_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         nxt();
         req_valid_i = (c < 8);
         req_wen_i = 1'b0;
         req_addr_i = 32'h400 + 32'(c) * 4;
         #3;
         if (c < 8) begin
            chk_cnt++;
            if (req_ready[2] !== 1'b1) $display("FAIL b2b_ready c%0d: got %b exp 1", c, req_ready[2]);
            else pass_cnt++;
         end
         if (c >= 3 && c < 11) begin
            chk_cnt++;
            if (resp_valid[2] !== 1'b1 || resp_rdata[2] !== (rd_base ^ (32'h400 + 32'(c - 3) * 4)))
               $display("FAIL b2b_resp c%0d: got v=%b d=%h exp v=1 d=%h", c, resp_valid[2],
                        resp_rdata[2], rd_base ^ (32'h400 + 32'(c - 3) * 4));
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (resp_valid[2] !== 1'b0) $display("FAIL b2b_tail: got %b exp 0", resp_valid[2]);
      else pass_cnt++;
      idle(8);
   endtask

   task automatic test_credit_stall();
      logic [31:0] a [3];
      logic        exp_rdy [6];
      a = '{32'h10, 32'h14, 32'h18};
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      rd_base = 32'h0BAD_0000;
      gnt_en = 1'b1;
      resp_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         nxt();
         req_valid_i = 1'b1; req_wen_i = 1'b0;
         req_addr_i = a[(c < 2) ? c : 2];
         resp_ready_i = (c == 5);
         #3;
         chk_cnt++;
         if (req_ready[0] !== exp_rdy[c])
            $display("FAIL cr_ready c%0d: got %b exp %b", c, req_ready[0], exp_rdy[c]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (resp_rdata[0] !== (rd_base ^ a[0])) $display("FAIL cr_r0: got %h exp %h", resp_rdata[0], rd_base ^ a[0]);
      else pass_cnt++;
      nxt();
      req_valid_i = 1'b0;
      #3;
      chk_cnt++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== (rd_base ^ a[1]))
         $display("FAIL cr_r1: got v=%b d=%h exp v=1 d=%h", resp_valid[0], resp_rdata[0], rd_base ^ a[1]);
      else pass_cnt++;
      nxt(); #3;
      chk_cnt++;
      if (resp_valid[0] !== 1'b0) $display("FAIL cr_gap: got %b exp 0", resp_valid[0]);
      else pass_cnt++;
      nxt(); #3;
      chk_cnt++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== (rd_base ^ a[2]))
         $display("FAIL cr_r2: got v=%b d=%h exp v=1 d=%h", resp_valid[0], resp_rdata[0], rd_base ^ a[2]);
      else pass_cnt++;
      idle(12);
   endtask

   task automatic test_push_pop();
      logic [31:0] a [3];
      a = '{32'h20, 32'h24, 32'h28};
      rd_base = 32'h7700_0000;
      gnt_en = 1'b1;
      resp_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         nxt();
         req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = a[c];
      end
      nxt();
      resp_ready_i = 1'b1;
      #3;
      chk_cnt++;
      if (req_ready[0] !== 1'b1) $display("FAIL pp_ready: got %b exp 1", req_ready[0]);
      else pass_cnt++;
      chk_cnt++;
      if (resp_rdata[0] !== (rd_base ^ a[0])) $display("FAIL pp_r0: got %h exp %h", resp_rdata[0], rd_base ^ a[0]);
      else pass_cnt++;
      for (int c = 4; c <= 7; c++) begin
         nxt();
         req_valid_i = 1'b0;
         resp_ready_i = (c >= 6);
         #3;
         chk_cnt++;
         if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== (rd_base ^ a[(c < 7) ? 1 : 2]))
            $display("FAIL pp_resp c%0d: got v=%b d=%h exp v=1 d=%h", c, resp_valid[0],
                     resp_rdata[0], rd_base ^ a[(c < 7) ? 1 : 2]);
         else pass_cnt++;
      end
      idle(12);
   endtask

   task automatic test_async_reset();
      rd_base = 32'h0;
      gnt_en = 1'b1;
      resp_ready_i = 1'b0;
      nxt();
      req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h30;
      nxt();
      req_addr_i = 32'h34;
      nxt();
      req_valid_i = 1'b0;
      gnt_en = 1'b0;
      #1;
      chk_cnt++;
      if (net_req[0] !== 1'b1 || net_add[0] !== 5'd13)
         $display("FAIL ar_pre: got req=%b add=%0d exp req=1 add=13", net_req[0], net_add[0]);
      else pass_cnt++;
      rst_ni = 1'b0;
      #1;
      chk_cnt++;
      if (net_req[0] !== 1'b0 || net_add[0] !== 5'd0 || net_data[0] !== 62'd0 || net_wen[0] !== 1'b0)
         $display("FAIL ar_net: got req=%b add=%0d data=%h wen=%b exp all 0",
                  net_req[0], net_add[0], net_data[0], net_wen[0]);
      else pass_cnt++;
      chk_cnt++;
      if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0)
         $display("FAIL ar_resp: got v=%b d=%h exp 0", resp_valid[0], resp_rdata[0]);
      else pass_cnt++;
      gnt_en = 1'b1;
      resp_ready_i = 1'b1;
      nxt(); nxt();
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         nxt(); #3;
         chk_cnt++;
         if (resp_valid[0] !== 1'b0 || net_req[0] !== 1'b0)
            $display("FAIL ar_stale c%0d: got v=%b req=%b exp 0", c, resp_valid[0], net_req[0]);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst_ni       = 1'b0;
      req_valid_i  = 1'b0;
      req_wen_i    = 1'b0;
      req_addr_i   = '0;
      req_be_i     = 4'hF;
      req_wdata_i  = '0;
      resp_ready_i = 1'b1;
      rd_base      = '0;
      gnt_en       = 1'b1;
      test_reset();
      test_read_latency();
      test_read_data();
      test_write_hold();
      test_back_to_back();
      test_credit_stall();
      test_push_pop();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
